mealy_1011: RTL and testbench

- Serial bit-stream sequence detector, implemented as a Mealy finite state machine.
- Asserts `out` combinationally in the same cycle that the final '1' of the pattern 1-0-1-1 is present on `in`.
- Sits on a single-bit serial data path clocked by the system clock; one input bit is consumed per rising edge.
- Overlapping detection is the default; non-overlapping detection is selectable by parameter.

---
 rtl/mealy_1011.sv | 69 ++++++
 tb/tb_mealy_1011.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mealy_1011.sv
// Mealy detector for serial pattern 1-0-1-1. The match flag is combinational in the cycle of the final bit,
// with zero latency. There is no backpressure: one bit is consumed on every rising edge of clk.
module mealy_1011 #(
    parameter int OVERLAP = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic out
);

    localparam logic [1:0] S0 = 2'b00;
    localparam logic [1:0] S1 = 2'b01;
    localparam logic [1:0] S2 = 2'b10;
    localparam logic [1:0] S3 = 2'b11;

    logic [1:0] r_state;
    logic [1:0] w_next;
    logic       w_hit_next;

    // After a match, the trailing '1' either seeds a new prefix or is dropped.
    assign w_hit_next = (OVERLAP != 0) ? S1 : S0;

    always_comb begin
        w_next = S0;
        case (r_state)
            S0: begin
                case (in)
                    1'b0:    w_next = S0;
                    1'b1:    w_next = S1;
                    default: w_next = S0;
                endcase
            end
            S1: begin
                case (in)
                    1'b0:    w_next = S2;
                    1'b1:    w_next = S1;
                    default: w_next = S0;
                endcase
            end
            S2: begin
                case (in)
                    1'b0:    w_next = S0;
                    1'b1:    w_next = S3;
                    default: w_next = S0;
                endcase
            end
            S3: begin
                case (in)
                    1'b0:    w_next = S2;
                    1'b1:    w_next = w_hit_next;
                    default: w_next = S0;
                endcase
            end
            default: w_next = S0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S0;
        end else begin
            r_state <= w_next;
        end
    end

    assign out = (r_state == S3) && (in == 1'b1) && !reset;

endmodule

// File: tb/tb_mealy_1011.sv
// Directed and random checks of mealy_1011, using one overlapping instance and one non-overlapping instance.
module tb_mealy_1011;

    logic clk;
    logic reset;
    logic in_bit;
    logic out_ov;
    logic out_no;

    int total;
    int bad;

    mealy_1011 #(.OVERLAP(1)) u_ov (.clk(clk), .reset(reset), .in(in_bit), .out(out_ov));
    mealy_1011 #(.OVERLAP(0)) u_no (.clk(clk), .reset(reset), .in(in_bit), .out(out_no));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A new bit is applied at the falling edge, and the outputs are read 1ns later.
    task automatic drive_bit(input logic b);
        @(negedge clk);
        in_bit = b;
        #1;
    endtask

    task automatic do_reset;
        @(negedge clk);
        in_bit = 1'b0;
        reset  = 1'b1;
        @(negedge clk);
        reset  = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_bit = i[0] ? 1'b0 : 1'b1;
            #1;
            total += 4;
            if (out_ov !== 1'b0) begin
                bad++;
                $display("FAIL reset_out_ov cycle %0d: got %b want 0", i, out_ov);
            end
            if (out_no !== 1'b0) begin
                bad++;
                $display("FAIL reset_out_no cycle %0d: got %b want 0", i, out_no);
            end
            if (u_ov.r_state !== 2'b00) begin
                bad++;
                $display("FAIL reset_state_ov cycle %0d: got %b want 00", i, u_ov.r_state);
            end
            if (u_no.r_state !== 2'b00) begin
                bad++;
                $display("FAIL reset_state_no cycle %0d: got %b want 00", i, u_no.r_state);
            end
        end
        @(negedge clk);
        in_bit = 1'b0;
        reset  = 1'b0;
        begin
            logic [3:0] s;
            logic [3:0] e;
            s = 4'b1011;
            e = 4'b0001;
            for (int i = 3; i >= 0; i--) begin
                drive_bit(s[i]);
                total += 2;
                if (out_ov !== e[i]) begin
                    bad++;
                    $display("FAIL post_reset_ov bit %0d: got %b want %b", 4 - i, out_ov, e[i]);
                end
                if (out_no !== e[i]) begin
                    bad++;
                    $display("FAIL post_reset_no bit %0d: got %b want %b", 4 - i, out_no, e[i]);
                end
            end
        end
    endtask

    task automatic test_overlap;
        logic [6:0] s;
        logic [6:0] eo;
        logic [6:0] en;
        s  = 7'b1011011;
        eo = 7'b0001001;
        en = 7'b0001000;
        do_reset();
        for (int i = 6; i >= 0; i--) begin
            drive_bit(s[i]);
            total += 2;
            if (out_ov !== eo[i]) begin
                bad++;
                $display("FAIL overlap_ov bit %0d: got %b want %b", 7 - i, out_ov, eo[i]);
            end
            if (out_no !== en[i]) begin
                bad++;
                $display("FAIL overlap_no bit %0d: got %b want %b", 7 - i, out_no, en[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] s;
        logic [7:0] e;
        s = 8'b10111011;
        e = 8'b00010001;
        do_reset();
        for (int i = 7; i >= 0; i--) begin
            drive_bit(s[i]);
            total += 2;
            if (out_ov !== e[i]) begin
                bad++;
                $display("FAIL b2b_ov bit %0d: got %b want %b", 8 - i, out_ov, e[i]);
            end
            if (out_no !== e[i]) begin
                bad++;
                $display("FAIL b2b_no bit %0d: got %b want %b", 8 - i, out_no, e[i]);
            end
        end
    endtask

    task automatic test_prefix_recovery;
        logic [6:0] s [3];
        logic [6:0] e [3];
        int         n [3];
        s[0] = 7'b0011011; e[0] = 7'b0000001; n[0] = 5;
        s[1] = 7'b0101011; e[1] = 7'b0000001; n[1] = 6;
        s[2] = 7'b1001011; e[2] = 7'b0000001; n[2] = 7;
        for (int v = 0; v < 3; v++) begin
            do_reset();
            for (int i = n[v] - 1; i >= 0; i--) begin
                drive_bit(s[v][i]);
                total += 2;
                if (out_ov !== e[v][i]) begin
                    bad++;
                    $display("FAIL prefix%0d_ov bit %0d: got %b want %b", v, n[v] - i, out_ov, e[v][i]);
                end
                if (out_no !== e[v][i]) begin
                    bad++;
                    $display("FAIL prefix%0d_no bit %0d: got %b want %b", v, n[v] - i, out_no, e[v][i]);
                end
            end
        end
    endtask

    task automatic test_async_reset;
        logic [3:0] s;
        logic [3:0] e;
        do_reset();
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        // Both instances sit in S3 with in=1, so without reset the output would be high.
        @(posedge clk);
        #2;
        in_bit = 1'b1;
        reset  = 1'b1;
        #1;
        total += 4;
        if (u_ov.r_state !== 2'b00) begin
            bad++;
            $display("FAIL async_state_ov: got %b want 00", u_ov.r_state);
        end
        if (u_no.r_state !== 2'b00) begin
            bad++;
            $display("FAIL async_state_no: got %b want 00", u_no.r_state);
        end
        if (out_ov !== 1'b0) begin
            bad++;
            $display("FAIL async_out_ov: got %b want 0", out_ov);
        end
        if (out_no !== 1'b0) begin
            bad++;
            $display("FAIL async_out_no: got %b want 0", out_no);
        end
        #1;
        reset = 1'b0;
        s = 4'b1011;
        e = 4'b0001;
        for (int i = 3; i >= 0; i--) begin
            drive_bit(s[i]);
            total += 2;
            if (out_ov !== e[i]) begin
                bad++;
                $display("FAIL async_tail_ov bit %0d: got %b want %b", 4 - i, out_ov, e[i]);
            end
            if (out_no !== e[i]) begin
                bad++;
                $display("FAIL async_tail_no bit %0d: got %b want %b", 4 - i, out_no, e[i]);
            end
        end
    endtask

    task automatic test_random_soak;
        logic [2:0] h_ov;
        logic [2:0] h_no;
        int         c_ov;
        int         c_no;
        logic       b;
        logic       x_ov;
        logic       x_no;
        h_ov = 3'b000; h_no = 3'b000;
        c_ov = 0;      c_no = 0;
        do_reset();
        for (int k = 0; k < 50; k++) begin
            b    = 1'($urandom_range(0, 1));
            x_ov = (c_ov >= 3) && (h_ov == 3'b101) && b;
            x_no = (c_no >= 3) && (h_no == 3'b101) && b;
            drive_bit(b);
            total += 2;
            if (out_ov !== x_ov) begin
                bad++;
                $display("FAIL soak_ov bit %0d: got %b want %b", k, out_ov, x_ov);
            end
            if (out_no !== x_no) begin
                bad++;
                $display("FAIL soak_no bit %0d: got %b want %b", k, out_no, x_no);
            end
            h_ov = {h_ov[1:0], b};
            c_ov = (c_ov < 3) ? c_ov + 1 : 3;
            if (x_no) begin
                h_no = 3'b000;
                c_no = 0;
            end else begin
                h_no = {h_no[1:0], b};
                c_no = (c_no < 3) ? c_no + 1 : 3;
            end
        end
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        reset  = 1'b1;
        in_bit = 1'b0;
        test_reset();
        test_overlap();
        test_back_to_back();
        test_prefix_recovery();
        test_async_reset();
        test_random_soak();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
